// File: rtl/alu_exec_sequencer_pkg.sv
// Shared types and constants for the ALU execute sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: ALU opcode enum, sequencer FSM state enum, default data width,
// and a helper that classifies opcodes as legal or not.
package exec_pkg;

    // Default datapath width; must match the width of the attached ALU.
    localparam int DEF_N = 8;

    // Opcodes understood by the ALU. Encodings 3..7 are illegal and make the
    // ALU return 0.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_AND = 3'd1,
        ALU_OR  = 3'd2
    } aluop_t;

    // Sequencer FSM states, one per cycle of the 4-cycle execute loop.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // True when the opcode is one the ALU actually implements.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= ALU_OR);
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_regfile.sv
// Register file with two combinational read ports, one debug read port and
// one synchronous write port. Latency: reads 0 cycles, write visible next cycle.
// Backpressure: none; always accepts a write when we is high.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high clear
//   we, waddr, wdata    write port (writes to address 0 are dropped)
//   raddr1/rdata1       read port 1
//   raddr2/rdata2       read port 2
//   dbg_addr/dbg_data   debug read port
// Register 0 reads as zero on every port and never stores a value.
module regfile_2r1w
    import exec_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr1,
    output logic [N-1:0]  rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [N-1:0]  rdata2,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    logic [N-1:0] mem_q [NREG];
    logic [N-1:0] mem_d [NREG];

    // Next-state of the array: only the addressed entry changes, and r0 is
    // never written so it stays at its reset value of zero.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Address 0 is forced to zero on the read side as well so that r0 reads
    // zero regardless of what the storage entry holds.
    assign rdata1   = (raddr1   == '0) ? '0 : mem_q[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : mem_q[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute sequencer wrapped around an external combinational ALU.
// Latency: handshake in cycle t, done pulse in t+3, next accept in t+4.
// Backpressure: instr_ready is high only in IDLE; one instruction per 4 cycles.
//
// Ports:
//   clk, reset                         rising-edge clock, sync active-high reset
//   instr_valid/instr_ready            instruction handshake
//   instr_op/rd/rs1/rs2/use_imm/imm    instruction fields, sampled on handshake
//   alu_op1/alu_op2/alu_op             registered operands/opcode to the ALU
//   alu_result/alu_zero                ALU result and zero flag
//   done/illegal_op                    one-cycle pulses at writeback
//   flag_zero                          zero flag of the last completed instruction
//   dbg_addr/dbg_data                  combinational register-file peek
module alu_exec_sequencer
    import exec_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic          instr_use_imm,
    input  logic [N-1:0]  instr_imm,
    output logic [N-1:0]  alu_op1,
    output logic [N-1:0]  alu_op2,
    output logic [2:0]    alu_op,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_zero,
    output logic          done,
    output logic          flag_zero,
    output logic          illegal_op,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    // ------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------
    state_t        state_q,     state_d;
    logic [2:0]    op_q,        op_d;
    logic [AW-1:0] rd_q,        rd_d;
    logic [AW-1:0] rs1_q,       rs1_d;
    logic [AW-1:0] rs2_q,       rs2_d;
    logic          use_imm_q,   use_imm_d;
    logic [N-1:0]  imm_q,       imm_d;
    logic [N-1:0]  op1_q,       op1_d;
    logic [N-1:0]  op2_q,       op2_d;
    logic [N-1:0]  res_q,       res_d;
    logic          z_q,         z_d;
    logic          flag_zero_q, flag_zero_d;

    // Register-file interface
    logic [N-1:0]  rf_rdata1;
    logic [N-1:0]  rf_rdata2;
    logic          rf_we;

    logic          accept;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    regfile_2r1w #(
        .N    (N),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (res_q),
        .raddr1   (rs1_q),
        .rdata1   (rf_rdata1),
        .raddr2   (rs2_q),
        .rdata2   (rf_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Ready is gated by reset directly so the upstream never sees ready while
    // reset is asserted, even though state_q only clears on the next edge.
    assign instr_ready = (state_q == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_imm_d   = use_imm_q;
        imm_d       = imm_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        res_d       = res_q;
        z_d         = z_q;
        flag_zero_d = flag_zero_q;

        case (state_q)
            IDLE: begin
                // Instruction fields are only captured on the handshake
                // cycle; whatever is on the bus at other times is ignored.
                if (accept) begin
                    op_d      = instr_op;
                    rd_d      = instr_rd;
                    rs1_d     = instr_rs1;
                    rs2_d     = instr_rs2;
                    use_imm_d = instr_use_imm;
                    imm_d     = instr_imm;
                    state_d   = READ;
                end
            end
            READ: begin
                // Operand fetch. The previous instruction's writeback has
                // already landed in the array, so dependent instructions see
                // the updated value without any bypass.
                op1_d   = rf_rdata1;
                op2_d   = use_imm_q ? imm_q : rf_rdata2;
                state_d = EXEC;
            end
            EXEC: begin
                // ALU inputs come straight from op1_q/op2_q/op_q, which are
                // stable for this whole cycle.
                res_d   = alu_result;
                z_d     = alu_zero;
                state_d = WB;
            end
            WB: begin
                flag_zero_d = z_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            res_q       <= '0;
            z_q         <= 1'b0;
            flag_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use_imm_q   <= use_imm_d;
            imm_q       <= imm_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            res_q       <= res_d;
            z_q         <= z_d;
            flag_zero_q <= flag_zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Writeback happens on the edge that leaves WB; a reset on that same edge
    // clears the register file instead, so an aborted instruction never
    // lands.
    assign rf_we      = (state_q == WB);
    assign done       = (state_q == WB);
    assign illegal_op = done && !is_legal_op(op_q);
    assign flag_zero  = flag_zero_q;

    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_op     = op_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
module tb_alu_exec_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_rs1;
    logic [2:0] instr_rs2;
    logic       instr_use_imm;
    logic [7:0] instr_imm;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       done;
    logic       flag_zero;
    logic       illegal_op;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: architectural register contents and last zero flag.
    logic [7:0] ref_rf [8];
    logic       ref_fz;

    always #5 clk = ~clk;

    // Behavioural ALU sitting beside the sequencer.
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_op1 + alu_op2;
            3'd1:    alu_result = alu_op1 & alu_op2;
            3'd2:    alu_result = alu_op1 | alu_op2;
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    alu_exec_sequencer #(.N(8), .NREG(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs1     (instr_rs1),
        .instr_rs2     (instr_rs2),
        .instr_use_imm (instr_use_imm),
        .instr_imm     (instr_imm),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .done          (done),
        .flag_zero     (flag_zero),
        .illegal_op    (illegal_op),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        if (op == 3'd0) return a + b;
        if (op == 3'd1) return a & b;
        if (op == 3'd2) return a | b;
        return 8'h00;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
        ref_fz = 1'b0;
    endtask

    // Issue one instruction, check latency, pulses and the architectural result.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic ui, input logic [7:0] imm);
        logic [7:0] a, b, res;
        int w, lat;
        a   = ref_rf[rs1];
        b   = ui ? imm : ref_rf[rs2];
        res = model_alu(op, a, b);

        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1;
        instr_rs2 = rs2; instr_use_imm = ui; instr_imm = imm;
        w = 0;
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the bus so a sequencer sampling outside the handshake shows up.
        instr_valid = 1'b0; instr_op = 3'($urandom); instr_rd = 3'($urandom);
        instr_rs1 = 3'($urandom); instr_rs2 = 3'($urandom);
        instr_use_imm = 1'($urandom); instr_imm = 8'($urandom);

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 8);
        chk("latency", lat, 3);
        chk("illegal_op", 32'(illegal_op), 32'(op > 3'd2));
        chk("ready_in_wb", 32'(instr_ready), 32'd0);

        if (rd != 3'd0) ref_rf[rd] = res;
        ref_fz = (res == 8'h00);

        @(negedge clk);
        dbg_addr = rd;
        #1;
        chk("rd_value", 32'(dbg_data), 32'(ref_rf[rd]));
        chk("flag_zero", 32'(flag_zero), 32'(ref_fz));
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int rdy_cnt, acc_cnt, done_cnt, last_rdy, k;
        reset = 1'b1; instr_valid = 1'b0; instr_op = 3'd0; instr_rd = 3'd0;
        instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_use_imm = 1'b0; instr_imm = 8'h00;
        dbg_addr = 3'd0;
        clear_model();

        // Reset state
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(instr_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(instr_ready), 32'd1);
        chk("done_reset", 32'(done), 32'd0);
        chk("illegal_reset", 32'(illegal_op), 32'd0);
        chk("fz_reset", 32'(flag_zero), 32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("rf_reset", 32'(dbg_data), 32'd0);
        end

        // Add
        run_instr(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'd5);
        run_instr(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 8'd3);
        run_instr(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        chk("r3_is_8", 32'(ref_rf[3]), 32'd8);
        // Wrap to zero
        run_instr(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hFF);
        run_instr(3'd0, 3'd4, 3'd1, 3'd0, 1'b1, 8'h01);
        // Logic ops
        run_instr(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hF0);
        run_instr(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 8'h0F);
        run_instr(3'd1, 3'd5, 3'd1, 3'd2, 1'b0, 8'h00);
        run_instr(3'd2, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00);
        // Dependent chain r1 = r1 + 1 from 0
        run_instr(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h00);
        repeat (3) run_instr(3'd0, 3'd1, 3'd1, 3'd0, 1'b1, 8'h01);
        chk("chain_r1_3", 32'(ref_rf[1]), 32'd3);
        // r0 write dropped, illegal op
        run_instr(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 8'd7);
        run_instr(3'd5, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00);

        // Backpressure: valid held high, r7 += 1 per accepted instruction.
        run_instr(3'd0, 3'd7, 3'd0, 3'd0, 1'b1, 8'h00);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd7; instr_rs1 = 3'd7;
        instr_use_imm = 1'b1; instr_imm = 8'h01;
        rdy_cnt = 0; acc_cnt = 0; done_cnt = 0; last_rdy = -4;
        for (k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (done) done_cnt++;
            if (instr_ready) begin
                rdy_cnt++;
                chk("ready_spacing", k - last_rdy, 4);
                last_rdy = k;
            end
            if (instr_ready && instr_valid) acc_cnt++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("bp_ready_count", rdy_cnt, 4);
        chk("bp_accept_count", acc_cnt, 4);
        chk("bp_done_count", done_cnt, 4);
        ref_rf[7] = ref_rf[7] + 8'(acc_cnt);
        ref_fz = (ref_rf[7] == 8'h00);
        @(negedge clk);
        dbg_addr = 3'd7;
        #1;
        chk("bp_r7", 32'(dbg_data), 32'(ref_rf[7]));
        chk("bp_r7_is_4", 32'(ref_rf[7]), 32'd4);

        // Randomized instructions
        for (int i = 0; i < 40; i++) begin
            run_instr((($urandom % 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
                      3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
        end

        // Reset in EXEC aborts the instruction.
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd3; instr_rs1 = 3'd0;
        instr_use_imm = 1'b1; instr_imm = 8'd9;
        k = 0;
        while (!instr_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);          // READ
        @(negedge clk);          // EXEC
        reset = 1'b1;
        #1;
        chk("ready_reset_midop", 32'(instr_ready), 32'd0);
        clear_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_abort", 32'(done), 32'd0);
            chk("ready_held_reset", 32'(instr_ready), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 32'(instr_ready), 32'd1);
        chk("done_after_abort", 32'(done), 32'd0);
        dbg_addr = 3'd3;
        #1;
        chk("abort_r3", 32'(dbg_data), 32'(ref_rf[3]));
        chk("abort_fz", 32'(flag_zero), 32'(ref_fz));
        // Sequencer still works after the abort.
        run_instr(3'd0, 3'd3, 3'd0, 3'd0, 1'b1, 8'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
